// File: rtl/ser_frame_rx.sv
// rtl/ser_frame_rx.sv - serial frame receiver: start-flag sync, abort-flag filtering, serial and word output
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-low reset
//   RcIn      in   serial line input, sampled every rising edge
//   txOut     out  forwarded payload bit
//   txValid   out  txOut holds a payload bit this cycle
//   txAbort   out  one-cycle pulse when a frame is aborted
//   wordOut   out  packed payload word, first received bit in the MSB
//   wordValid out  one-cycle pulse, wordOut valid
//   frameDone out  one-cycle pulse with the last payload bit of a frame
//   bitCount  out  payload bits forwarded in the current frame
module ser_frame_rx #(
    parameter int                FLAG_W     = 8,
    parameter logic [FLAG_W-1:0] START_FLAG = 8'h7E,
    parameter logic [FLAG_W-1:0] ABORT_FLAG = 8'h81,
    parameter int                DATA_W     = 8,
    parameter int                MAX_BITS   = 96,
    parameter int                LEN_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RcIn,
    output logic              txOut,
    output logic              txValid,
    output logic              txAbort,
    output logic [DATA_W-1:0] wordOut,
    output logic              wordValid,
    output logic              frameDone,
    output logic [LEN_W-1:0]  bitCount
);

    localparam int FC_W = $clog2(FLAG_W + 1);
    localparam int WC_W = $clog2(DATA_W + 1);

    localparam logic [LEN_W-1:0] WIN_CNT    = LEN_W'(FLAG_W);
    localparam logic [LEN_W-1:0] MAX_CNT    = LEN_W'(MAX_BITS);
    localparam logic [FC_W-1:0]  FLUSH_INIT = FC_W'(FLAG_W - 1);
    localparam logic [WC_W-1:0]  FULL_CNT   = WC_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_FLUSH
    } state_t;

    state_t              r_state;
    logic [FLAG_W-1:0]   r_sr;
    logic [LEN_W-1:0]    r_rx_cnt;
    logic [FC_W-1:0]     r_flush_cnt;
    logic [DATA_W-1:0]   r_wsh;
    logic [WC_W-1:0]     r_wcnt;

    logic                r_tx_out;
    logic                r_tx_valid;
    logic                r_tx_abort;
    logic [DATA_W-1:0]   r_word_out;
    logic                r_word_valid;
    logic                r_frame_done;
    logic [LEN_W-1:0]    r_bit_cnt;

    logic                w_window;
    logic                w_abort;
    logic                w_emit;
    logic                w_last;
    logic                w_bit;
    logic                w_word_full;
    logic [DATA_W-1:0]   w_word_next;
    logic [WC_W-1:0]     w_pad;
    logic [DATA_W-1:0]   w_word_pad;

    // The shift register holds only payload once FLAG_W payload bits have
    // been sampled; before that it still contains start-flag bits.
    assign w_window    = (r_rx_cnt >= WIN_CNT);
    assign w_abort     = (r_state == S_DATA) && w_window && (r_sr == ABORT_FLAG);
    assign w_emit      = ((r_state == S_DATA) && w_window && !w_abort) ||
                         ((r_state == S_FLUSH) && (r_flush_cnt != '0));
    assign w_last      = (r_state == S_FLUSH) && (r_flush_cnt == FC_W'(1));
    assign w_bit       = r_sr[FLAG_W-1];
    assign w_word_full = (r_wcnt == FULL_CNT);
    assign w_word_next = {r_wsh[DATA_W-2:0], w_bit};
    // Left-align a short final word; the shift also drops stale upper bits.
    assign w_pad       = FULL_CNT - r_wcnt;
    assign w_word_pad  = w_word_next << w_pad;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_sr         <= '0;
            r_rx_cnt     <= '0;
            r_flush_cnt  <= '0;
            r_wsh        <= '0;
            r_wcnt       <= '0;
            r_tx_out     <= 1'b0;
            r_tx_valid   <= 1'b0;
            r_tx_abort   <= 1'b0;
            r_word_out   <= '0;
            r_word_valid <= 1'b0;
            r_frame_done <= 1'b0;
            r_bit_cnt    <= '0;
        end else begin
            r_sr         <= {r_sr[FLAG_W-2:0], RcIn};
            r_tx_out     <= 1'b0;
            r_tx_valid   <= 1'b0;
            r_tx_abort   <= 1'b0;
            r_word_valid <= 1'b0;
            r_frame_done <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (r_sr == START_FLAG) begin
                        // The bit sampled on this edge is payload bit 0.
                        r_state   <= S_DATA;
                        r_rx_cnt  <= LEN_W'(1);
                        r_bit_cnt <= '0;
                        r_wsh     <= '0;
                        r_wcnt    <= '0;
                    end
                end
                S_DATA: begin
                    if (w_abort) begin
                        r_tx_abort <= 1'b1;
                        r_sr       <= '0;
                        r_state    <= S_IDLE;
                    end else if (r_rx_cnt == MAX_CNT) begin
                        // Last bit is sampled; drain the FLAG_W-1 bits still held.
                        r_state     <= S_FLUSH;
                        r_flush_cnt <= FLUSH_INIT;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + LEN_W'(1);
                    end
                end
                S_FLUSH: begin
                    if (r_flush_cnt == '0) begin
                        r_sr    <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_flush_cnt <= r_flush_cnt - FC_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            if (w_emit) begin
                r_tx_valid <= 1'b1;
                r_tx_out   <= w_bit;
                r_bit_cnt  <= r_bit_cnt + LEN_W'(1);
                if (w_word_full) begin
                    r_word_out   <= w_word_next;
                    r_word_valid <= 1'b1;
                    r_wsh        <= '0;
                    r_wcnt       <= '0;
                end else begin
                    r_wsh  <= w_word_next;
                    r_wcnt <= r_wcnt + WC_W'(1);
                    if (w_last) begin
                        r_word_out   <= w_word_pad;
                        r_word_valid <= 1'b1;
                    end
                end
                if (w_last) begin
                    r_frame_done <= 1'b1;
                end
            end
        end
    end

    assign txOut     = r_tx_out;
    assign txValid   = r_tx_valid;
    assign txAbort   = r_tx_abort;
    assign wordOut   = r_word_out;
    assign wordValid = r_word_valid;
    assign frameDone = r_frame_done;
    assign bitCount  = r_bit_cnt;

endmodule

// File: tb/tb_ser_frame_rx.sv
// tb/tb_ser_frame_rx.sv - directed scoreboard bench for ser_frame_rx
module tb_ser_frame_rx;

    logic       clk  = 1'b0;
    logic       rst  = 1'b0;
    logic       rc_a = 1'b0;
    logic       rc_b = 1'b0;

    logic       to_a, tv_a, ta_a, wv_a, fd_a;
    logic [7:0] wo_a, bc_a;
    logic       to_b, tv_b, ta_b, wv_b, fd_b;
    logic [7:0] wo_b, bc_b;

    ser_frame_rx u_dut (
        .clk(clk), .rst(rst), .RcIn(rc_a),
        .txOut(to_a), .txValid(tv_a), .txAbort(ta_a),
        .wordOut(wo_a), .wordValid(wv_a), .frameDone(fd_a), .bitCount(bc_a)
    );

    ser_frame_rx #(.MAX_BITS(100)) u_dut100 (
        .clk(clk), .rst(rst), .RcIn(rc_b),
        .txOut(to_b), .txValid(tv_b), .txAbort(ta_b),
        .wordOut(wo_b), .wordValid(wv_b), .frameDone(fd_b), .bitCount(bc_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    typedef struct { logic b; logic last; int cyc; } exp_bit_t;
    typedef struct { logic [7:0] w; int cyc; } exp_word_t;

    exp_bit_t  q_bits[$];
    exp_word_t q_words[$];

    logic       sel_b = 1'b0;
    logic       mon_en = 1'b0;
    int         exp_abort_cyc = -1;
    int         cur_max = 96;
    int         m_idx;
    int         m_n;
    logic [7:0] m_acc;

    logic       m_out, m_valid, m_abort, m_wv, m_fd;
    logic [7:0] m_word;
    logic       o_valid, o_abort, o_wv, o_fd;
    assign m_out   = sel_b ? to_b : to_a;
    assign m_valid = sel_b ? tv_b : tv_a;
    assign m_abort = sel_b ? ta_b : ta_a;
    assign m_wv    = sel_b ? wv_b : wv_a;
    assign m_fd    = sel_b ? fd_b : fd_a;
    assign m_word  = sel_b ? wo_b : wo_a;
    assign o_valid = sel_b ? tv_a : tv_b;
    assign o_abort = sel_b ? ta_a : ta_b;
    assign o_wv    = sel_b ? wv_a : wv_b;
    assign o_fd    = sel_b ? fd_a : fd_b;

    exp_bit_t  mb;
    exp_word_t mw;
    logic      ev, ew;

    always @(negedge clk) begin
        if (mon_en) begin
            ev = (q_bits.size() > 0) && (q_bits[0].cyc == cyc);
            check("txValid", m_valid, ev);
            if (ev) begin
                mb = q_bits.pop_front();
                if (m_valid) begin
                    check("txOut", m_out, mb.b);
                    check("frameDone", m_fd, mb.last);
                end
            end else begin
                check("idle_out", {m_out, m_fd}, 2'b00);
            end
            ew = (q_words.size() > 0) && (q_words[0].cyc == cyc);
            check("wordValid", m_wv, ew);
            if (ew) begin
                mw = q_words.pop_front();
                if (m_wv) check("wordOut", m_word, mw.w);
            end
            check("txAbort", m_abort, (cyc == exp_abort_cyc));
            check("other_quiet", {o_valid, o_abort, o_wv, o_fd}, 4'b0000);
        end
    end

    task automatic drive(input logic b);
        if (sel_b) begin
            rc_b = b;
            rc_a = 1'b0;
        end else begin
            rc_a = b;
            rc_b = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0);
    endtask

    task automatic send_raw(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) drive(v[i]);
    endtask

    task automatic start_frame(input int max_bits);
        cur_max = max_bits;
        m_idx   = 0;
        m_n     = 0;
        m_acc   = 8'h00;
        send_raw(8'h7E);
    endtask

    // Payload bit sampled at edge E must appear in the cycle after edge E+8.
    task automatic pay(input logic b, input logic fwd);
        exp_bit_t  eb;
        exp_word_t ewd;
        logic [7:0] pad;
        drive(b);
        if (fwd) begin
            eb.b    = b;
            eb.last = (m_idx == cur_max - 1);
            eb.cyc  = cyc + 8;
            q_bits.push_back(eb);
            m_acc = {m_acc[6:0], b};
            m_n++;
            if (m_n == 8) begin
                ewd.w   = m_acc;
                ewd.cyc = cyc + 8;
                q_words.push_back(ewd);
                m_n = 0;
            end else if (eb.last) begin
                pad     = m_acc << (8 - m_n);
                ewd.w   = pad;
                ewd.cyc = cyc + 8;
                q_words.push_back(ewd);
            end
            m_idx++;
        end
    endtask

    task automatic pay_byte(input logic [7:0] v, input logic fwd);
        for (int i = 7; i >= 0; i--) pay(v[i], fwd);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 60 && (q_bits.size() + q_words.size()) != 0; i++) drive(1'b0);
        check(tag, q_bits.size() + q_words.size(), 0);
        idle(4);
    endtask

    logic [7:0] f7e;
    logic [7:0] rnd_byte;
    logic       rb;
    int         zrun;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {to_a, tv_a, ta_a, wo_a, wv_a, fd_a, bc_a}, 21'h0);
        rst    = 1'b1;
        mon_en = 1'b1;

        // 1: default frame of 0xA5 bytes
        idle(10);
        start_frame(96);
        for (int i = 0; i < 12; i++) pay_byte(8'hA5, 1'b1);
        drain("t1_drain");
        check("t1_bitcount", bc_a, 8'd96);

        // 2: 40 random bits then abort flag; runs of six zeros are broken so
        // the abort pattern cannot appear early
        idle(5);
        start_frame(96);
        zrun = 0;
        for (int i = 0; i < 40; i++) begin
            rnd_byte = 8'($urandom_range(0, 255));
            rb = rnd_byte[0];
            if (zrun == 5) rb = 1'b1;
            zrun = rb ? 0 : zrun + 1;
            pay(rb, 1'b1);
        end
        pay_byte(8'h81, 1'b0);
        exp_abort_cyc = cyc + 1;
        idle(10);
        drain("t2_drain");
        check("t2_bitcount", bc_a, 8'd40);

        // 3: abort flag and near-miss start flag in IDLE are ignored
        idle(3);
        send_raw(8'h81);
        send_raw(8'h7F);
        idle(20);
        check("t3_bitcount_hold", bc_a, 8'd40);

        // 4: start flag embedded in payload at bit offset 20
        f7e = 8'h7E;
        start_frame(96);
        for (int k = 0; k < 96; k++) begin
            if (k >= 20 && k < 28) pay(f7e[27-k], 1'b1);
            else pay(k[0], 1'b1);
        end
        drain("t4_drain");
        check("t4_bitcount", bc_a, 8'd96);

        // 5: MAX_BITS=100 instance, all ones, short final word
        sel_b = 1'b1;
        idle(5);
        start_frame(100);
        for (int k = 0; k < 100; k++) pay(1'b1, 1'b1);
        drain("t5_drain");
        check("t5_bitcount", bc_b, 8'd100);
        sel_b = 1'b0;
        idle(5);

        // 6: asynchronous reset mid-frame, then a clean frame
        start_frame(96);
        for (int k = 0; k < 30; k++) pay(k[0] ^ k[1], 1'b1);
        check("t6_pre_rst_bitcount", bc_a, 8'd22);
        check("t6_pre_rst_valid", tv_a, 1'b1);
        #2;
        rst = 1'b0;
        q_bits.delete();
        q_words.delete();
        #1;
        check("t6_async_rst", {to_a, tv_a, ta_a, wo_a, wv_a, fd_a, bc_a}, 21'h0);
        idle(3);
        rst = 1'b1;
        idle(5);
        start_frame(96);
        for (int i = 0; i < 12; i++) pay_byte(8'h96, 1'b1);
        drain("t6_drain");
        check("t6_bitcount", bc_a, 8'd96);

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
